landing_queue: RTL and testbench

LANDING_QUEUE -- requirements
Module: landing_queue

---
 rtl/landing_queue.sv | 149 ++++++++++++++
 tb/tb_landing_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/landing_queue.sv
// Landing request FIFO feeding a single-runway dispatcher with a post-dispatch clearance window.
// Build macro EMERGENCY_PRIORITY_EN adds a one-entry class-3 emergency slot served ahead of the FIFO.
module landing_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLEAR_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_class,
  input  logic [3:0] req_id,
  input  logic       runway_blocked,
  output logic       E,
  output logic [1:0] d,
  output logic [3:0] dispatch_id,
  output logic       busy,
  output logic [4:0] count
);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DISPATCH, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [5:0]    mem_q [DEPTH];
  logic [5:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    fifo_cnt_q, fifo_cnt_d;
  logic [7:0]    clr_cnt_q, clr_cnt_d;
  logic [1:0]    d_q, d_d;
  logic [3:0]    id_q, id_d;
  logic          fifo_ready, fifo_push, fifo_pop, launch;
`ifdef EMERGENCY_PRIORITY_EN
  logic          slot_v_q, slot_v_d, from_slot_q, from_slot_d, slot_push;
  logic [3:0]    slot_id_q, slot_id_d;
`endif

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    d_d        = d_q;
    id_d       = id_q;
    fifo_pop   = 1'b0;
    fifo_ready = (fifo_cnt_q < 5'(DEPTH));
`ifdef EMERGENCY_PRIORITY_EN
    slot_v_d    = slot_v_q;
    slot_id_d   = slot_id_q;
    from_slot_d = from_slot_q;
    slot_push   = req_valid && (req_class == 2'b11) && !slot_v_q;
    fifo_push   = req_valid && (req_class != 2'b11) && fifo_ready;
    req_ready   = (req_class == 2'b11) ? !slot_v_q : fifo_ready;
    count       = fifo_cnt_q + {4'b0000, slot_v_q};
`else
    fifo_push   = req_valid && fifo_ready;
    req_ready   = fifo_ready;
    count       = fifo_cnt_q;
`endif

    // The final CLEAR cycle makes the IDLE decision itself, so dispatches
    // stay CLEAR_CYCLES+1 apart instead of losing a cycle passing through IDLE.
    launch = (count != '0) && !runway_blocked &&
             ((state_q == IDLE) || ((state_q == CLEAR) && (clr_cnt_q == '0)));

    unique case (state_q)
      IDLE: begin
        if (launch) state_d = DISPATCH;
      end
      DISPATCH: begin
        state_d   = CLEAR;
        clr_cnt_d = 8'(CLEAR_CYCLES - 1);
`ifdef EMERGENCY_PRIORITY_EN
        if (from_slot_q) slot_v_d = 1'b0;
        else             fifo_pop = 1'b1;
`else
        fifo_pop = 1'b1;
`endif
      end
      CLEAR: begin
        if (clr_cnt_q == '0) state_d = launch ? DISPATCH : IDLE;
        else                 clr_cnt_d = clr_cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      {d_d, id_d} = mem_q[rd_ptr_q];
`ifdef EMERGENCY_PRIORITY_EN
      from_slot_d = slot_v_q;
      if (slot_v_q) begin
        d_d  = 2'b11;
        id_d = slot_id_q;
      end
`endif
    end

`ifdef EMERGENCY_PRIORITY_EN
    if (slot_push) begin
      slot_v_d  = 1'b1;
      slot_id_d = req_id;
    end
`endif

    if (fifo_push) begin
      mem_d[wr_ptr_q] = {req_class, req_id};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (fifo_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    fifo_cnt_d = fifo_cnt_q + 5'(fifo_push) - 5'(fifo_pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      clr_cnt_q   <= '0;
      d_q         <= '0;
      id_q        <= '0;
`ifdef EMERGENCY_PRIORITY_EN
      slot_v_q    <= 1'b0;
      slot_id_q   <= '0;
      from_slot_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      d_q         <= d_d;
      id_q        <= id_d;
`ifdef EMERGENCY_PRIORITY_EN
      slot_v_q    <= slot_v_d;
      slot_id_q   <= slot_id_d;
      from_slot_q <= from_slot_d;
`endif
    end
  end

  assign E           = (state_q == DISPATCH);
  assign busy        = (state_q != IDLE);
  assign d           = d_q;
  assign dispatch_id = id_q;
endmodule

// File: tb/tb_landing_queue.sv
// Self-checking bench for landing_queue: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a timeline-based reference model.
module tb_landing_queue;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned CLEAR_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, runway_blocked, E, busy;
  logic [1:0] req_class, d;
  logic [3:0] req_id, dispatch_id;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  landing_queue #(.DEPTH(DEPTH), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_id(req_id), .runway_blocked(runway_blocked),
    .E(E), .d(d), .dispatch_id(dispatch_id), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] c,
                       input logic [3:0] i, input logic b);
    rst = r; req_valid = v; req_class = c; req_id = i; runway_blocked = b;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: a queue of {class,id}, optional emergency slot, and the
  // number of runway-reserved cycles remaining (dispatch cycle included).
  logic [5:0] mq[$];
  logic       m_slot_v, m_src_slot;
  logic [3:0] m_slot_id, m_id;
  logic [1:0] m_d;
  int         m_rem;

  function automatic logic m_ready(input logic [1:0] c);
`ifdef EMERGENCY_PRIORITY_EN
    if (c == 2'b11) return !m_slot_v;
`endif
    return (mq.size() < DEPTH);
  endfunction

  function automatic int m_count();
    return mq.size() + (m_slot_v ? 1 : 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_slot_v = 0; m_slot_id = 0; m_src_slot = 0; m_d = 0; m_id = 0; m_rem = 0;
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [1:0] c,
                            input logic [3:0] i, input logic b);
    logic acc, start;
    if (r) begin
      model_reset();
      return;
    end
    acc   = v && m_ready(c);
    start = (m_rem <= 1) && (m_count() > 0) && !b;
    if (m_rem == CLEAR_CYCLES + 1) begin
      if (m_src_slot) m_slot_v = 0;
      else void'(mq.pop_front());
    end
    if (start) begin
      m_rem = CLEAR_CYCLES + 1;
      m_src_slot = m_slot_v;
      if (m_slot_v) begin m_d = 2'b11; m_id = m_slot_id; end
      else {m_d, m_id} = mq[0];
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (acc) begin
`ifdef EMERGENCY_PRIORITY_EN
      if (c == 2'b11) begin m_slot_v = 1; m_slot_id = i; end
      else mq.push_back({c, i});
`else
      mq.push_back({c, i});
`endif
    end
  endtask

  typedef struct {
    logic       valid;
    logic [1:0] cls;
    logic [3:0] id;
    logic       blk;
    logic       exp_e;
    logic [1:0] exp_d;
    logic [3:0] exp_id;
    logic       exp_busy;
    logic [4:0] exp_cnt;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int         n_e;
    int         e_t[8];
    logic [3:0] e_id[8];
    logic [1:0] e_d[8];
    logic [3:0] exp_ids[3];
    logic [1:0] exp_ds[3];
    logic       found;
    logic       r, v, b;
    logic [1:0] c;
    logic [3:0] i;
    int         pct;

    // Single request {01,5} into an empty queue with default parameters.
    vecs[0] = '{1'b1, 2'b01, 4'd5, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 5'd1, 1'b1};
    vecs[1] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 2'b01, 4'd5, 1'b1, 5'd1, 1'b1};
    for (int k = 2; k <= 9; k++)
      vecs[k] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 2'b01, 4'd5, 1'b1, 5'd0, 1'b1};
    vecs[10] = '{1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 2'b01, 4'd5, 1'b0, 5'd0, 1'b1};

    // Reset with a request offered: nothing stored, all outputs cleared.
    @(negedge clk);
    drive(1, 1, 2'b01, 4'hF, 0);
    step(); step();
    chk("rst_E", E, 0);
    chk("rst_d", d, 0);
    chk("rst_id", dispatch_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    drive(0, 0, 2'b00, 4'h0, 0);
    #1 chk("rst_ready", req_ready, 1);

    foreach (vecs[k]) begin
      drive(0, vecs[k].valid, vecs[k].cls, vecs[k].id, vecs[k].blk);
      step();
      chk($sformatf("vec%0d_E", k), E, vecs[k].exp_e);
      chk($sformatf("vec%0d_d", k), d, vecs[k].exp_d);
      chk($sformatf("vec%0d_id", k), dispatch_id, vecs[k].exp_id);
      chk($sformatf("vec%0d_busy", k), busy, vecs[k].exp_busy);
      chk($sformatf("vec%0d_count", k), count, vecs[k].exp_cnt);
      chk($sformatf("vec%0d_ready", k), req_ready, vecs[k].exp_ready);
    end

    // Fill and overflow while blocked: ids 1..4 stored, id 5 refused.
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 2'b01, 4'(k), 1);
      #1 chk($sformatf("ovf_ready_pre%0d", k), req_ready, (k <= 4));
      step();
      chk($sformatf("ovf_count%0d", k), count, (k <= 4) ? k : 4);
      chk($sformatf("ovf_busy%0d", k), busy, 0);
    end
    chk("ovf_ready_full", req_ready, 0);
    drive(0, 0, 2'b00, 4'h0, 1);
    step();
    chk("ovf_count_hold", count, 4);

    // Release: four dispatches in order, CLEAR_CYCLES+1 apart.
    drive(0, 0, 2'b00, 4'h0, 0);
    n_e = 0;
    for (int t = 0; t < 50; t++) begin
      step();
      if (E && n_e < 8) begin
        e_t[n_e] = t; e_id[n_e] = dispatch_id; e_d[n_e] = d; n_e++;
      end
    end
    chk("ord_npulses", n_e, 4);
    for (int k = 0; k < 4 && k < n_e; k++) begin
      chk($sformatf("ord_id%0d", k), e_id[k], k + 1);
      chk($sformatf("ord_d%0d", k), e_d[k], 2'b01);
      if (k > 0) chk($sformatf("ord_gap%0d", k), e_t[k] - e_t[k-1], CLEAR_CYCLES + 1);
    end
    chk("ord_count_end", count, 0);

    // Reset during the 3rd CLEAR cycle with two entries still queued.
    for (int k = 6; k <= 8; k++) begin
      drive(0, 1, 2'b01, 4'(k), 1);
      step();
    end
    drive(0, 0, 2'b00, 4'h0, 0);
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      step();
      if (E) found = 1;
    end
    chk("mid_found_E", found, 1);
    step(); step(); step();
    chk("mid_busy_clear3", busy, 1);
    chk("mid_count_clear3", count, 2);
    drive(1, 0, 2'b00, 4'h0, 0);
    step();
    chk("mid_E", E, 0);
    chk("mid_busy", busy, 0);
    chk("mid_count", count, 0);
    drive(0, 0, 2'b00, 4'h0, 0);
    #1 chk("mid_ready", req_ready, 1);
    n_e = 0;
    for (int t = 0; t < 30; t++) begin
      step();
      if (E) n_e++;
    end
    chk("mid_no_E", n_e, 0);

    // Emergency class-3 request queued behind two normal requests.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, (k == 2) ? 2'b11 : 2'b01, (k == 2) ? 4'd9 : 4'(k + 1), 1);
      step();
    end
    drive(0, 0, 2'b00, 4'h0, 0);
`ifdef EMERGENCY_PRIORITY_EN
    exp_ids[0] = 9; exp_ids[1] = 1; exp_ids[2] = 2;
    exp_ds[0] = 2'b11; exp_ds[1] = 2'b01; exp_ds[2] = 2'b01;
`else
    exp_ids[0] = 1; exp_ids[1] = 2; exp_ids[2] = 9;
    exp_ds[0] = 2'b01; exp_ds[1] = 2'b01; exp_ds[2] = 2'b11;
`endif
    n_e = 0;
    for (int t = 0; t < 60; t++) begin
      step();
      if (E && n_e < 8) begin
        e_id[n_e] = dispatch_id; e_d[n_e] = d; n_e++;
      end
    end
    chk("emg_npulses", n_e, 3);
    for (int k = 0; k < 3 && k < n_e; k++) begin
      chk($sformatf("emg_id%0d", k), e_id[k], exp_ids[k]);
      chk($sformatf("emg_d%0d", k), e_d[k], exp_ds[k]);
    end

    // Randomized traffic against the reference model.
    drive(1, 0, 2'b00, 4'h0, 0);
    step(); step();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      pct = ((n / 500) % 2 == 1) ? 6 : 40;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 99) < pct);
      c = 2'($urandom_range(0, 3));
      i = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0);
      drive(r, v, c, i, b);
      #1 chk("rnd_ready", req_ready, m_ready(c));
      @(posedge clk);
      model_edge(r, v, c, i, b);
      @(negedge clk);
      chk("rnd_E", E, (m_rem == CLEAR_CYCLES + 1));
      chk("rnd_busy", busy, (m_rem > 0));
      chk("rnd_count", count, m_count());
      chk("rnd_d", d, m_d);
      chk("rnd_id", dispatch_id, m_id);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
